// File: rtl/alu_seq_nbit_if.sv
// alu_seq_nbit_if: operand/result bus between the accumulator controller and the sequential ALU
//   master: drives start, op, in0, in1, c_in; observes busy, done, results and flags
//   slave : the ALU side of the same bundle
interface alu_seq_nbit_if #(parameter int N = 8);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] in0;
    logic [N-1:0] in1;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result_lo;
    logic [N-1:0] result_hi;
    logic         c_out;
    logic         V;
    logic         Z;
    logic         Nf;
    logic         E;

    modport master (
        output start, op, in0, in1, c_in,
        input  busy, done, result_lo, result_hi, c_out, V, Z, Nf, E
    );

    modport slave (
        input  start, op, in0, in1, c_in,
        output busy, done, result_lo, result_hi, c_out, V, Z, Nf, E
    );
endinterface

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered N-bit ALU with iterative unsigned multiply/divide and start/busy/done handshake
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu_seq_nbit_if (request, operands, results, flags)
module alu_seq_nbit #(
    parameter int N = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_nbit_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] work_q, work_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic           div_q, div_d;
    logic           done_q, done_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   hi_q, hi_d;
    logic           c_q, c_d;
    logic           v_q, v_d;
    logic           z_q, z_d;
    logic           e_q, e_d;

    logic           iter;
    logic [N-1:0]   b_eff;
    logic [N:0]     ar_sum;
    logic           ar_v;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_diff;
    logic [2*N-1:0] step;

    // MUL and DIV with a non-zero divisor go through the iterative engine
    assign iter   = bus.op[2] & bus.op[1] & (~bus.op[0] | (bus.in1 != '0));
    // SUB is in0 + ~in1 + 1, sharing the ADD adder
    assign b_eff  = (bus.op == OP_SUB) ? ~bus.in1 : bus.in1;
    assign ar_sum = {1'b0, bus.in0} + {1'b0, b_eff}
                  + {{N{1'b0}}, (bus.op == OP_SUB) ? 1'b1 : bus.c_in};
    // carry into the MSB recovered from the MSB sum bit, xor'd with carry out
    assign ar_v   = (bus.in0[N-1] ^ b_eff[N-1] ^ ar_sum[N-1]) ^ ar_sum[N];

    // work_q holds {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = work_q[2*N-1:N-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign step      = !div_q      ? {mul_sum, work_q[N-1:1]} :
                       div_diff[N] ? {div_shift[N-1:0], work_q[N-2:0], 1'b0} :
                                     {div_diff[N-1:0], work_q[N-2:0], 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        done_d  = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        e_d     = e_q;
        if (state_q == IDLE && bus.start) begin
            if (iter) begin
                state_d = RUN;
                cnt_d   = CW'(N);
                div_d   = bus.op[0];
                opnd_d  = bus.op[0] ? bus.in1 : bus.in0;
                work_d  = {{N{1'b0}}, bus.op[0] ? bus.in0 : bus.in1};
            end else begin
                done_d = 1'b1;
                hi_d   = '0;
                c_d    = 1'b0;
                v_d    = 1'b0;
                e_d    = 1'b0;
                case (bus.op)
                    OP_ADD, OP_SUB: begin
                        lo_d = ar_sum[N-1:0];
                        c_d  = ar_sum[N];
                        v_d  = ar_v;
                    end
                    OP_OR:   lo_d = bus.in0 | bus.in1;
                    OP_AND:  lo_d = bus.in0 & bus.in1;
                    OP_NOT:  lo_d = ~bus.in0;
                    OP_XOR:  lo_d = bus.in0 ^ bus.in1;
                    // only divide-by-zero reaches here
                    default: begin
                        lo_d = '1;
                        hi_d = bus.in0;
                        e_d  = 1'b1;
                    end
                endcase
                z_d = (lo_d == '0);
            end
        end else if (state_q == RUN) begin
            work_d = step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = step[2*N-1:N];
                lo_d    = step[N-1:0];
                c_d     = 1'b0;
                e_d     = 1'b0;
                v_d     = !div_q && (step[2*N-1:N] != '0);
                z_d     = div_q ? (step[N-1:0] == '0) : (step == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            e_q     <= e_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.c_out     = c_q;
    assign bus.V         = v_q;
    assign bus.Z         = z_q;
    assign bus.Nf        = lo_q[N-1];
    assign bus.E         = e_q;
endmodule

// File: tb/tb_alu_seq_nbit.sv
// tb_alu_seq_nbit: directed table-driven bench for alu_seq_nbit (N=8)
module tb_alu_seq_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    alu_seq_nbit_if #(.N(8)) bus ();
    alu_seq_nbit #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] lo, hi;
        logic       c, v, z, nf, e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] lo, hi,
                           input logic c, v, z, nf, e);
        chk({nm, " lo"}, 16'(bus.result_lo), 16'(lo));
        chk({nm, " hi"}, 16'(bus.result_hi), 16'(hi));
        chk({nm, " c_out"}, 16'(bus.c_out), 16'(c));
        chk({nm, " V"}, 16'(bus.V), 16'(v));
        chk({nm, " Z"}, 16'(bus.Z), 16'(z));
        chk({nm, " Nf"}, 16'(bus.Nf), 16'(nf));
        chk({nm, " E"}, 16'(bus.E), 16'(e));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Multi-cycle op: checks busy length, hold of old results, ignored start, final results
    task automatic run_iter(input string nm, input logic [2:0] o, input logic [7:0] a, b,
                            input int poke_at, input logic [7:0] hold_lo, hold_hi,
                            input logic [7:0] e_lo, e_hi, input logic e_v, e_z);
        int nb = 0;
        bit got = 0;
        bit hold_ok = 1;
        bit excl_ok = 1;
        bus.start = 1'b1;
        bus.op = o;
        bus.in0 = a;
        bus.in1 = b;
        tick();
        bus.start = 1'b0;
        bus.in0 = 8'h33;
        bus.in1 = 8'h44;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                got = 1;
                if (bus.busy) excl_ok = 0;
                break;
            end
            if (bus.busy) nb++;
            if (bus.result_lo !== hold_lo || bus.result_hi !== hold_hi) hold_ok = 0;
            bus.start = (k == poke_at);
            bus.op = 3'b000;
            bus.in0 = 8'h01;
            bus.in1 = 8'h01;
            tick();
        end
        bus.start = 1'b0;
        chk({nm, " done seen"}, 16'(got), 16'd1);
        chk({nm, " busy cycles"}, 16'(nb), 16'd8);
        chk({nm, " held old result"}, 16'(hold_ok), 16'd1);
        chk({nm, " done/busy exclusive"}, 16'(excl_ok), 16'd1);
        chk_out(nm, e_lo, e_hi, 1'b0, e_v, e_z, e_lo[7], 1'b0);
        tick();
        chk({nm, " single done"}, 16'(bus.done), 16'd0);
        chk({nm, " result stable"}, {bus.result_hi, bus.result_lo}, {e_hi, e_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 8'h10, 8'h20, 1'b1, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 8'h03, 8'h05, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 8'hF0, 8'h0F, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd3, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 8'h5A, 8'hFF, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd5, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd7, 8'h05, 8'h00, 1'b0, 8'hFF, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.in0 = 8'h00;
        bus.in1 = 8'h00;
        bus.c_in = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("reset busy", 16'(bus.busy), 16'd0);
        chk("reset done", 16'(bus.done), 16'd0);
        chk_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // single-cycle ops back-to-back with start held high
        for (int i = 0; i < 12; i++) begin
            bus.start = 1'b1;
            bus.op = vecs[i].op;
            bus.in0 = vecs[i].a;
            bus.in1 = vecs[i].b;
            bus.c_in = vecs[i].ci;
            tick();
            chk($sformatf("vec%0d done", i), 16'(bus.done), 16'd1);
            chk($sformatf("vec%0d busy", i), 16'(bus.busy), 16'd0);
            chk_out($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].c,
                    vecs[i].v, vecs[i].z, vecs[i].nf, vecs[i].e);
        end
        bus.start = 1'b0;
        bus.c_in = 1'b0;
        tick();
        chk("idle done", 16'(bus.done), 16'd0);
        chk("idle hold lo", 16'(bus.result_lo), 16'h02);

        // SUB 5-5 then SUB 3-5 on consecutive edges
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.in0 = 8'h05;
        bus.in1 = 8'h05;
        tick();
        chk("sub1 done", 16'(bus.done), 16'd1);
        chk_out("sub1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.in0 = 8'h03;
        tick();
        chk("sub2 done", 16'(bus.done), 16'd1);
        chk_out("sub2", 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();

        run_iter("mul ff*ff", 3'd6, 8'hFF, 8'hFF, 3, 8'hFE, 8'h00, 8'h01, 8'hFE, 1'b1, 1'b0);
        run_iter("div 200/7", 3'd7, 8'd200, 8'd7, -1, 8'h01, 8'hFE, 8'h1C, 8'h04, 1'b0, 1'b0);
        run_iter("mul 10*10", 3'd6, 8'h10, 8'h10, -1, 8'h1C, 8'h04, 8'h00, 8'h01, 1'b1, 1'b0);
        run_iter("mul 0*5", 3'd6, 8'h00, 8'h05, -1, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
        run_iter("div 7/200", 3'd7, 8'd7, 8'd200, -1, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1);

        // reset in the middle of a MUL
        bus.start = 1'b1;
        bus.op = 3'd6;
        bus.in0 = 8'h03;
        bus.in1 = 8'h03;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", 16'(bus.busy), 16'd0);
        chk("mid reset done", 16'(bus.done), 16'd0);
        chk_out("mid reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done || bus.busy) seen = 1;
        end
        chk("no done after reset", 16'(seen), 16'd0);
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.in0 = 8'h10;
        bus.in1 = 8'h20;
        tick();
        bus.start = 1'b0;
        chk("post reset add done", 16'(bus.done), 16'd1);
        chk_out("post reset add", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
